// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl
// Reset sequencer/arbiter placed in front of the core reset path.
// - Merges NSRC enabled reset requests into one restart condition ("hit").
// - Holds every domain in reset for HOLD_CYC cycles after the last hit.
// - Releases NDOM domains in index order, with gap_q extra cycles between
//   successive releases.
// - Keeps sticky cause bits for every enabled request seen since the last clear.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high hard reset
//   req_i        in   [NSRC] reset requests, level or pulse
//   req_mask_i   in   [NSRC] 1 = source enabled
//   gap_i        in   [GAP_W] extra cycles between domain releases
//   cause_clr_i  in   clear for cause_o (a simultaneous set wins)
//   dom_rst_n_o  out  [NDOM] per-domain active-low reset, registered
//   cause_o      out  [NSRC] sticky cause bits
//   busy_o       out  high while the sequence is running
//   done_o       out  one-cycle pulse when the sequence completes
module rst_seq_ctrl #(
    parameter int NSRC     = 4,
    parameter int NDOM     = 3,
    parameter int HOLD_CYC = 16,
    parameter int GAP_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  req_i,
    input  logic [NSRC-1:0]  req_mask_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             cause_clr_i,
    output logic [NDOM-1:0]  dom_rst_n_o,
    output logic [NSRC-1:0]  cause_o,
    output logic             busy_o,
    output logic             done_o
);

    // The counter must hold both HOLD_CYC-1 and the largest gap value
    // without wrapping.
    localparam int CMAX = (HOLD_CYC > (1 << GAP_W)) ? HOLD_CYC : (1 << GAP_W);
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (NDOM > 1) ? $clog2(NDOM) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ASSERT  = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [NDOM-1:0]  dom_q, dom_d;
    logic [NSRC-1:0]  cause_q, cause_d;
    logic             done_q, done_d;
    logic             hit;

    assign hit = |(req_i & req_mask_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        dom_d   = dom_q;
        done_d  = 1'b0;
        cause_d = (cause_clr_i ? '0 : cause_q) | (req_i & req_mask_i);

        if (hit) begin
            // A hit restarts the sequence from any state, including on
            // the edge that would otherwise complete it.
            state_d = S_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
        end else begin
            case (state_q)
                S_ASSERT: begin
                    if (cnt_q == CW'(HOLD_CYC - 1)) begin
                        state_d  = S_RELEASE;
                        cnt_d    = '0;
                        idx_d    = '0;
                        gap_d    = gap_i;   // gap frozen for the whole release phase
                        dom_d[0] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == CW'(gap_q)) begin
                        cnt_d = '0;
                        if (idx_q != IW'(NDOM - 1)) begin
                            idx_d = idx_q + IW'(1);
                            for (int i = 1; i < NDOM; i++) begin
                                if (idx_q == IW'(i - 1)) dom_d[i] = 1'b1;
                            end
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_IDLE: begin
                    dom_d = '1;
                end
                default: begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            dom_q   <= '0;
            cause_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            dom_q   <= dom_d;
            cause_q <= cause_d;
            done_q  <= done_d;
        end
    end

    assign dom_rst_n_o = dom_q;
    assign cause_o     = cause_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl.
// Reference model: the whole sequence is a function of how many edges have
// passed since the last hit (or reset). Domain i is released once that age
// reaches HOLD + i*(gap+1); the sequence ends at HOLD + NDOM*(gap+1).
module tb_rst_seq_ctrl;
    localparam int NSRC  = 4;
    localparam int NDOM  = 3;
    localparam int HOLD  = 16;
    localparam int GAP_W = 4;
    localparam int EW    = NDOM + NSRC + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NSRC-1:0]  req;
    logic [NSRC-1:0]  mask;
    logic [GAP_W-1:0] gap;
    logic             clr;
    logic [NDOM-1:0]  dom;
    logic [NSRC-1:0]  cause;
    logic             busy;
    logic             done;

    rst_seq_ctrl #(.NSRC(NSRC), .NDOM(NDOM), .HOLD_CYC(HOLD), .GAP_W(GAP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .req_mask_i  (mask),
        .gap_i       (gap),
        .cause_clr_i (clr),
        .dom_rst_n_o (dom),
        .cause_o     (cause),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // model state
    int              age   = 0;
    int              gapm  = 0;
    logic [NSRC-1:0] mcause = '0;

    // One clock: let the DUT sample the current inputs, advance the model
    // with the same inputs and queue the expected post-edge outputs.
    task automatic step();
        logic [NDOM-1:0] edom;
        logic            ebusy, edone;
        int              fin;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            age    = 0;
            mcause = '0;
        end else begin
            if (|(req & mask)) age = 0;
            else if (age < 1000) age++;
            if (age == HOLD) gapm = int'(gap);
            mcause = (clr ? '0 : mcause) | (req & mask);
        end
        for (int i = 0; i < NDOM; i++) edom[i] = (age >= HOLD + i * (gapm + 1));
        fin   = HOLD + NDOM * (gapm + 1);
        ebusy = (age < fin);
        edone = (age == fin);
        exp_q.push_back({edom, mcause, ebusy, edone});
    endtask

    // Monitor: the DUT presents a full output word every cycle.
    always @(negedge clk) begin
        logic [EW-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dom, cause, busy, done};
            total++;
            if (a === e) passed++;
            else $display("FAIL outputs cyc=%0d {dom,cause,busy,done} got=%b exp=%b", cyc, a, e);
        end
    end

    initial begin
        rst = 1'b1; req = '0; mask = 4'hF; gap = 4'd2; clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        // power-up sequence, gap 2
        repeat (30) step();
        // single-cycle pulse from idle
        req = 4'b0100; step(); req = '0;
        // request arriving after dom0/dom1 are released
        repeat (20) step();
        req = 4'b0010; step(); req = '0;
        repeat (30) step();
        // masked request held, then enabled one held
        mask = 4'b1110; req = 4'b0001;
        repeat (20) step();
        req = 4'b0010;
        repeat (10) step();
        req = '0;
        repeat (30) step();
        // set wins over clear
        mask = 4'hF; req = 4'b0011; step();
        req = '0; step();
        clr = 1'b1; req = 4'b1000; step();
        clr = 1'b0; req = '0;
        repeat (30) step();
        // back-to-back releases, gap change mid-release ignored
        gap = 4'd0; req = 4'b0001; step(); req = '0;
        repeat (17) step();
        gap = 4'd15;
        repeat (40) step();
        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            req  = ($urandom_range(0, 49) == 0) ? 4'($urandom) : '0;
            if ($urandom_range(0, 99) == 0) mask = 4'($urandom);
            gap  = 4'($urandom);
            clr  = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0; req = '0; clr = 1'b0;
        repeat (100) step();
        // bounded drain of the scoreboard
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
